xor_map_engine: RTL
===================

XOR_MAP_ENGINE -- requirements
Module: xor_map_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: word-address width of the state RAM.
REQ-002 SHALL have parameter DATA_W, default 32: word width, u32 view of the execution environment.
REQ-003 SHALL have parameter LEN_W, default 9: length field width, so a full 256-word pass is expressible.
REQ-004 SHALL have parameter FLAG_N, default 8: number of condition flags.
REQ-005 SHALL have port clk, in, 1: the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset, in, 1: synchronous, active-high.
REQ-007 SHALL have port op_valid, in, 1 and op_ready, out, 1: operation descriptor handshake.
REQ-008 SHALL have ports op_origin and op_modifier, each in, ADDR_W: destination base and modifier base.
REQ-009 SHALL have port op_length, in, LEN_W: number of words to process.
REQ-010 SHALL have port op_cond_en, in, 1: 0 means execute unconditionally.
REQ-011 SHALL have port op_cond_idx, in, clog2(FLAG_N): selects the gating flag.
REQ-012 SHALL have port flags, in, FLAG_N: condition flags, sampled only on the accept cycle.
REQ-013 SHALL have ports rd_a_addr and rd_b_addr, out, ADDR_W: RAM read addresses; read data returns 1 cycle later.
REQ-014 SHALL have ports rd_a_data and rd_b_data, in, DATA_W: RAM read data; on a same-cycle write to the same address the RAM returns old data.
REQ-015 SHALL have ports wr_en (out, 1), wr_addr (out, ADDR_W) and wr_data (out, DATA_W): RAM write port.
REQ-016 SHALL have port done, out, 1: one-cycle pulse at operation completion.
REQ-017 SHALL have port busy, out, 1: high whenever the state is not IDLE.

Function
REQ-018 SHALL implement the semantics: for i = 0..L-1 in order, mem[origin+i] = mem[origin+i] XOR mem[modifier+i]; each element uses the results of all earlier elements.
REQ-019 SHALL use FSM states IDLE, RUN and DRAIN; op_ready is 1 only in IDLE; an operation is accepted on op_valid and op_ready high at cycle T.
REQ-020 SHALL, on accept, latch all descriptor fields and evaluate the condition once: cond = !op_cond_en or flags[op_cond_idx].
REQ-021 SHALL, if op_length is 0 or cond is 0, perform no writes, pulse done at T+1 and return to IDLE, with op_ready high at T+2.
REQ-022 SHALL otherwise be in RUN for cycles T+1..T+L and issue reads for element k at cycle T+1+k.
REQ-023 SHALL write element k at cycle T+2+k with wr_addr = origin+k, in DRAIN for the last write.
REQ-024 SHALL pulse done with the last write at cycle T+L+1, and SHALL have op_ready high at T+L+2.
REQ-025 SHALL compute all addresses modulo 2^ADDR_W, so base+k wraps past the top of memory.
REQ-026 SHALL forward wr_data in place of RAM data on either read port whose read address equals the write address in flight in the same cycle; this is required for overlapping ranges.
REQ-027 SHALL, when origin equals modifier, write 0 to every element.
REQ-028 SHALL keep wr_en at 0 outside the write cycles; wr_addr and wr_data are don't-care when wr_en is 0.

Reset
REQ-029 SHALL, on reset, go to IDLE with op_ready=1, wr_en=0, done=0, busy=0, and the counter and latched descriptor at 0.
REQ-030 SHALL, on reset mid-operation, abort immediately: no writes from the cycle after reset is sampled, and no done pulse.

Structure
REQ-031 SHALL define the descriptor struct (origin, modifier, length, cond_en, cond_idx), the FSM state enum and the parameter defaults in the shared XorMap package.
REQ-032 SHALL have one sub-module, xor_map_bypass: a 2-read-port forwarding mux comparing read addresses against the in-flight write.

Verification
REQ-033 SHALL verify: mem[0..3]={1,2,3,4}, mem[16..19]={F,F,F,F}, origin 0, modifier 16, len 4 -> mem[0..3]={E,D,C,B}, done at T+5, 4 writes.
REQ-034 SHALL verify the overlap case: mem[0..3]={1,2,4,8}, origin 1, modifier 0, len 3 -> mem[1..3]={3,7,F} (bypass exercised).
REQ-035 SHALL verify: op_cond_en=1, flags=0x00, idx 3, len 5 -> no wr_en, done at T+1; then flags=0x08 -> 5 writes.
REQ-036 SHALL verify wrap: origin 254, modifier 0, len 4 -> writes at 254, 255, 0, 1.
REQ-037 SHALL verify: len 0 -> done at T+1, no writes; origin equals modifier, len 2 -> both words written 0.
REQ-038 SHALL verify: reset asserted at T+2 of a len-8 op -> wr_en low from T+3, no done, op_ready=1 at T+3.

Source files
------------

// File: rtl/xor_map_engine_pkg.sv
// Shared types and default sizes for the XOR map engine: descriptor layout
// and FSM state encoding.
package xor_map_engine_pkg;

   localparam int XM_ADDR_W = 8;
   localparam int XM_DATA_W = 32;
   localparam int XM_LEN_W  = 9;
   localparam int XM_FLAG_N = 8;
   localparam int XM_IDX_W  = $clog2(XM_FLAG_N);

   typedef enum logic [1:0] {
      XM_IDLE  = 2'd0,
      XM_RUN   = 2'd1,
      XM_DRAIN = 2'd2
   } xm_state_e;

   typedef struct packed {
      logic [XM_ADDR_W-1:0] origin;
      logic [XM_ADDR_W-1:0] modifier;
      logic [XM_LEN_W-1:0]  length;
      logic                 cond_en;
      logic [XM_IDX_W-1:0]  cond_idx;
   } xm_desc_t;

endpackage

// File: rtl/xor_map_bypass.sv
// Read-data forwarding for the two RAM read ports: a read issued in the same
// cycle as a write to that address gets the written value instead of stale RAM data.
module xor_map_bypass #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rd_a_addr,
   input  logic [ADDR_W-1:0] rd_b_addr,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [DATA_W-1:0] ram_a_data,
   input  logic [DATA_W-1:0] ram_b_data,
   output logic [DATA_W-1:0] a_data,
   output logic [DATA_W-1:0] b_data
);

   logic              hit_a;
   logic              hit_b;
   logic [DATA_W-1:0] fwd_data;

   // The RAM returns read data one cycle late, so the address match and the
   // colliding write value are registered to line up with that data.
   always_ff @(posedge clk) begin
      if (reset) begin
         hit_a    <= 1'b0;
         hit_b    <= 1'b0;
         fwd_data <= '0;
      end else begin
         hit_a    <= wr_en && (rd_a_addr == wr_addr);
         hit_b    <= wr_en && (rd_b_addr == wr_addr);
         fwd_data <= wr_data;
      end
   end

   assign a_data = hit_a ? fwd_data : ram_a_data;
   assign b_data = hit_b ? fwd_data : ram_b_data;

endmodule

// File: rtl/xor_map_engine.sv
// Sequential in-place XOR of a modifier range into an origin range of an
// external state RAM, one element per cycle, with optional flag gating.
module xor_map_engine
   import xor_map_engine_pkg::*;
#(
   parameter int ADDR_W = XM_ADDR_W,
   parameter int DATA_W = XM_DATA_W,
   parameter int LEN_W  = XM_LEN_W,
   parameter int FLAG_N = XM_FLAG_N
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      op_valid,
   output logic                      op_ready,
   input  logic [ADDR_W-1:0]         op_origin,
   input  logic [ADDR_W-1:0]         op_modifier,
   input  logic [LEN_W-1:0]          op_length,
   input  logic                      op_cond_en,
   input  logic [$clog2(FLAG_N)-1:0] op_cond_idx,
   input  logic [FLAG_N-1:0]         flags,
   output logic [ADDR_W-1:0]         rd_a_addr,
   output logic [ADDR_W-1:0]         rd_b_addr,
   input  logic [DATA_W-1:0]         rd_a_data,
   input  logic [DATA_W-1:0]         rd_b_data,
   output logic                      wr_en,
   output logic [ADDR_W-1:0]         wr_addr,
   output logic [DATA_W-1:0]         wr_data,
   output logic                      done,
   output logic                      busy,
   output xm_state_e                 fsm_state,
   output xm_desc_t                  op_latched
);

   // Handshake: a descriptor transfers on a rising edge where op_valid and
   // op_ready are both high; op_ready is high exactly when the FSM is idle.

   // The descriptor struct is laid out with the package widths.
   if (ADDR_W != XM_ADDR_W || LEN_W != XM_LEN_W || FLAG_N != XM_FLAG_N) begin : g_width_check
      $error("xor_map_engine: ADDR_W/LEN_W/FLAG_N must match xor_map_engine_pkg");
   end

   xm_state_e         state;
   xm_desc_t          desc;
   logic [LEN_W-1:0]  cnt;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [ADDR_W-1:0] offset;
   logic              cond;
   logic              last;
   logic [DATA_W-1:0] a_data;
   logic [DATA_W-1:0] b_data;

   assign cond   = !op_cond_en || flags[op_cond_idx];
   assign last   = (cnt == desc.length - LEN_W'(1));
   assign offset = ADDR_W'(cnt);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= XM_IDLE;
         desc      <= '0;
         cnt       <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
      end else begin
         wr_en_q <= 1'b0;
         case (state)
            XM_IDLE: begin
               if (op_valid) begin
                  desc <= '{origin:   op_origin,
                            modifier: op_modifier,
                            length:   op_length,
                            cond_en:  op_cond_en,
                            cond_idx: op_cond_idx};
                  cnt  <= '0;
                  // Skipped operations still pass through DRAIN for the done pulse.
                  state <= (op_length == '0 || !cond) ? XM_DRAIN : XM_RUN;
               end
            end
            XM_RUN: begin
               wr_en_q   <= 1'b1;
               wr_addr_q <= desc.origin + offset;
               cnt       <= cnt + LEN_W'(1);
               if (last) state <= XM_DRAIN;
            end
            XM_DRAIN: state <= XM_IDLE;
            default:  state <= XM_IDLE;
         endcase
      end
   end

   assign rd_a_addr = desc.origin + offset;
   assign rd_b_addr = desc.modifier + offset;

   xor_map_bypass #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_bypass (
      .clk        (clk),
      .reset      (reset),
      .rd_a_addr  (rd_a_addr),
      .rd_b_addr  (rd_b_addr),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .ram_a_data (rd_a_data),
      .ram_b_data (rd_b_data),
      .a_data     (a_data),
      .b_data     (b_data)
   );

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = a_data ^ b_data;
   assign done       = (state == XM_DRAIN);
   assign busy       = (state != XM_IDLE);
   assign op_ready   = (state == XM_IDLE);
   assign fsm_state  = state;
   assign op_latched = desc;

endmodule
